vga_timing_gen: RTL and testbench

//  - Generates 640x480@60Hz VGA raster timing from the 100 MHz board clock.
//  - Drives the pixel coordinate bus (xx, yy, aactive) consumed by every sprite stage, plus monitor syncs.
//  - Emits a pixel strobe and an end-of-active-frame pulse; game logic uses the pulse to move sprites during blanking.

---
 rtl/vga_timing_gen.sv | 128 ++++++++++++
 tb/tb_vga_timing_gen.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60Hz VGA raster timing generator: pixel strobe, coordinates, syncs, end-of-active-frame pulse.
// Optional feature: define VGA_FRAME_CNT_EN to add the 16-bit o_frame_cnt output.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_pix_stb,
  output logic [9:0]  xx,
  output logic [9:0]  yy,
  output logic        aactive,
  output logic        o_hs,
  output logic        o_vs,
`ifdef VGA_FRAME_CNT_EN
  output logic [15:0] o_frame_cnt,
`endif
  output logic        o_frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] H_ACT_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_chk
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_chk
    $error("vga_timing_gen: CLK_DIV must be within 1..16");
  end

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_xx;
  logic [9:0]       r_yy;
  logic             r_pix_stb;
  logic             r_aactive;
  logic             r_hs;
  logic             r_vs;
  logic             r_frame_end;

  logic             w_adv;
  logic [DIV_W-1:0] w_div_nxt;
  logic [9:0]       w_xx_nxt;
  logic [9:0]       w_yy_nxt;
  logic             w_frame_end_nxt;

  // Status flags are derived from the next-state coordinates so they move on the same edge as xx/yy.
  always_comb begin
    w_adv           = (r_div == DIV_LAST);
    w_div_nxt       = w_adv ? '0 : r_div + 1'b1;
    w_xx_nxt        = r_xx;
    w_yy_nxt        = r_yy;
    w_frame_end_nxt = w_adv && (r_xx == H_ACT_LAST) && (r_yy == V_ACT_LAST);
    if (w_adv) begin
      if (r_xx == H_LAST) begin
        w_xx_nxt = '0;
        w_yy_nxt = (r_yy == V_LAST) ? '0 : r_yy + 10'd1;
      end else begin
        w_xx_nxt = r_xx + 10'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_div       <= '0;
      r_xx        <= '0;
      r_yy        <= '0;
      r_pix_stb   <= 1'b0;
      r_aactive   <= 1'b0;
      r_hs        <= ~SYNC_POL;
      r_vs        <= ~SYNC_POL;
      r_frame_end <= 1'b0;
    end else begin
      r_div       <= w_div_nxt;
      r_xx        <= w_xx_nxt;
      r_yy        <= w_yy_nxt;
      r_pix_stb   <= (w_div_nxt == DIV_LAST);
      r_aactive   <= (w_xx_nxt < H_ACT) && (w_yy_nxt < V_ACT);
      r_hs        <= ((w_xx_nxt >= HS_FIRST) && (w_xx_nxt <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
      r_vs        <= ((w_yy_nxt >= VS_FIRST) && (w_yy_nxt <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
      r_frame_end <= w_frame_end_nxt;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_frame_cnt <= '0;
    end else if (w_frame_end_nxt) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
`endif

  assign o_pix_stb   = r_pix_stb;
  assign xx          = r_xx;
  assign yy          = r_yy;
  assign aactive     = r_aactive;
  assign o_hs        = r_hs;
  assign o_vs        = r_vs;
  assign o_frame_end = r_frame_end;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench for vga_timing_gen: two reduced-geometry instances (CLK_DIV=4 and CLK_DIV=1)
// checked every clock against an arithmetic raster model across random mid-frame resets.
module tb_vga_timing_gen;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 10, VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;
  localparam int FE_PIX = (VA - 1) * HT + (HA - 1);

  typedef struct {
    logic stb;
    int   x;
    int   y;
    logic act;
    logic hs;
    logic vs;
    logic fe;
    int   fc;
  } obs_t;

  typedef struct {
    obs_t a;
    obs_t b;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_stb, a_act, a_hs, a_vs, a_fe;
  logic        b_stb, b_act, b_hs, b_vs, b_fe;
  logic [9:0]  a_xx, a_yy, b_xx, b_yy;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] a_fc, b_fc;
`endif

  pair_t q[$];
  int    n_vec  = 0;
  int    n_fail = 0;
  int    k      = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .SYNC_POL(1'b0)
  ) u_dut4 (
    .i_clk(clk), .i_rst(rst_n), .o_pix_stb(a_stb), .xx(a_xx), .yy(a_yy),
    .aactive(a_act), .o_hs(a_hs), .o_vs(a_vs),
`ifdef VGA_FRAME_CNT_EN
    .o_frame_cnt(a_fc),
`endif
    .o_frame_end(a_fe)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .SYNC_POL(1'b0)
  ) u_dut1 (
    .i_clk(clk), .i_rst(rst_n), .o_pix_stb(b_stb), .xx(b_xx), .yy(b_yy),
    .aactive(b_act), .o_hs(b_hs), .o_vs(b_vs),
`ifdef VGA_FRAME_CNT_EN
    .o_frame_cnt(b_fc),
`endif
    .o_frame_end(b_fe)
  );

  // Expected outputs after k clock edges since reset release (k=0 means in reset).
  function automatic obs_t model(input int kk, input int div);
    obs_t o;
    int   p, pix;
    o.stb = 1'b0; o.x = 0; o.y = 0; o.act = 1'b0;
    o.hs = 1'b1; o.vs = 1'b1; o.fe = 1'b0; o.fc = 0;
    if (kk > 0) begin
      p     = kk / div;
      pix   = p % FT;
      o.x   = pix % HT;
      o.y   = pix / HT;
      o.stb = ((kk % div) == div - 1);
      o.act = (o.x < HA) && (o.y < VA);
      o.hs  = !((o.x >= HA + HFP) && (o.x < HA + HFP + HSW));
      o.vs  = !((o.y >= VA + VFP) && (o.y < VA + VFP + VSW));
      o.fe  = ((kk % div) == 0) && (p >= 1) && (((p - 1) % FT) == FE_PIX);
      o.fc  = (p - 1 >= FE_PIX) ? ((p - 1 - FE_PIX) / FT + 1) : 0;
    end
    return o;
  endfunction

  function automatic void push_exp(input int kk);
    pair_t e;
    e.a = model(kk, 4);
    e.b = model(kk, 1);
    q.push_back(e);
  endfunction

  function automatic void check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    pair_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("div4.stb", int'(a_stb), int'(e.a.stb));
      check("div4.xx",  int'(a_xx),  e.a.x);
      check("div4.yy",  int'(a_yy),  e.a.y);
      check("div4.act", int'(a_act), int'(e.a.act));
      check("div4.hs",  int'(a_hs),  int'(e.a.hs));
      check("div4.vs",  int'(a_vs),  int'(e.a.vs));
      check("div4.fe",  int'(a_fe),  int'(e.a.fe));
      check("div1.stb", int'(b_stb), int'(e.b.stb));
      check("div1.xx",  int'(b_xx),  e.b.x);
      check("div1.yy",  int'(b_yy),  e.b.y);
      check("div1.act", int'(b_act), int'(e.b.act));
      check("div1.hs",  int'(b_hs),  int'(e.b.hs));
      check("div1.vs",  int'(b_vs),  int'(e.b.vs));
      check("div1.fe",  int'(b_fe),  int'(e.b.fe));
`ifdef VGA_FRAME_CNT_EN
      check("div4.fcnt", int'(a_fc), e.a.fc % 65536);
      check("div1.fcnt", int'(b_fc), e.b.fc % 65536);
`endif
    end
  end

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      k++;
      push_exp(k);
    end
  endtask

  // Assert reset between edges so the next sample only passes if reset acts asynchronously.
  task automatic mid_reset(input int hold);
    @(posedge clk);
    #1 rst_n = 1'b0;
    k = 0;
    push_exp(0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      push_exp(0);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      push_exp(0);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    run(3 * FT * 4 + 37);
    mid_reset(2);
    run((5 * HT + 10) * 4 + 1);
    mid_reset(1);
    run(FT * 4 + 5);
    for (int r = 0; r < 6; r++) begin
      run(int'($urandom_range(40, 1500)));
      mid_reset(int'($urandom_range(0, 4)));
    end
    run(int'($urandom_range(200, 900)));
    for (int t = 0; t < 4 && q.size() > 0; t++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
